shared_bus_arbiter: RTL and testbench

SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

---
 rtl/shared_bus_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/shared_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_shared_bus_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/shared_bus_pkg.sv
// Shared types and parameter limits for the shared-bus arbiter.
// Optional weak bus keeper is enabled with SHARED_BUS_KEEPER_EN.
package shared_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StTurn
  } state_e;

  localparam int unsigned NChMin     = 2;
  localparam int unsigned NChMax     = 16;
  localparam int unsigned WidthMin   = 1;
  localparam int unsigned WidthMax   = 32;
  localparam int unsigned MaxHoldMin = 1;
  localparam int unsigned MaxHoldMax = 255;
  localparam int unsigned TurnMax    = 3;

  localparam int unsigned HoldW = $clog2(MaxHoldMax + 1);
  localparam int unsigned TurnW = $clog2(TurnMax + 1);

  function automatic bit params_ok(input int unsigned n_ch, input int unsigned width,
                                   input int unsigned max_hold, input int unsigned turn);
    return (n_ch >= NChMin) && (n_ch <= NChMax) && (width >= WidthMin) &&
           (width <= WidthMax) && (max_hold >= MaxHoldMin) && (max_hold <= MaxHoldMax) &&
           (turn <= TurnMax);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last owner, so the
// last owner is considered last and only wins when it is the sole requester.
module rr_arbiter #(
  parameter int unsigned NCh  = 4,
  parameter int unsigned IdxW = $clog2(NCh)
) (
  input  logic [NCh-1:0]  req_i,
  input  logic [IdxW-1:0] last_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  int unsigned cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= NCh; k++) begin
      cand = (int'(last_i) + k) % NCh;
      if (!valid_o && req_i[IdxW'(cand)]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with hold limit and turnaround gap.
// Define SHARED_BUS_KEEPER_EN to weakly hold the last driven value while released.
module shared_bus_arbiter
  import shared_bus_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_HOLD   = 4,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*WIDTH-1:0] wdata,
  output logic [N_CH-1:0]       gnt,
  inout  tri   [WIDTH-1:0]      bus,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic                  conflict
);

  localparam int unsigned IdxW = $clog2(N_CH);

  if (!params_ok(N_CH, WIDTH, MAX_HOLD, TURNAROUND)) begin : gen_param_range_error
    $error("shared_bus_arbiter: parameter out of range");
  end

  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);
  localparam logic [HoldW-1:0] HoldSat  = HoldW'(MAX_HOLD);
  localparam logic [TurnW-1:0] TurnInit = TurnW'((TURNAROUND == 0) ? 0 : TURNAROUND - 1);
  localparam logic [IdxW-1:0]  LastInit = IdxW'(N_CH - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [TurnW-1:0]  turn_q, turn_d;
  logic [N_CH-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  rdata_q;
  logic              conflict_q, conflict_d;
  logic              arb_valid;
  logic [IdxW-1:0]   arb_idx;
  logic              arbitrate;
  logic              drive_en;
  logic [WIDTH-1:0]  drive_data;
  logic [WIDTH-1:0]  wdata_ch [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : gen_wdata
    assign wdata_ch[c] = wdata[c*WIDTH +: WIDTH];
  end

  // Driver enable comes straight from the grant register so reset releases the bus at once.
  assign drive_en   = |gnt_q;
  assign drive_data = wdata_ch[owner_q];
  assign bus        = drive_en ? drive_data : {WIDTH{1'bz}};

  rr_arbiter #(
    .NCh  (N_CH),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i   (req),
    .last_i  (owner_q),
    .valid_o (arb_valid),
    .idx_o   (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    gnt_d      = gnt_q;
    arbitrate  = 1'b0;
    conflict_d = conflict_q | (drive_en && (bus !== drive_data));

    unique case (state_q)
      StIdle: arbitrate = 1'b1;
      StOwn: begin
        if (!req[owner_q] || ((hold_q >= HoldLast) && |(req & ~gnt_q))) begin
          if (TURNAROUND == 0) begin
            arbitrate = 1'b1;
          end else begin
            state_d = StTurn;
            gnt_d   = '0;
            turn_d  = TurnInit;
          end
        end else if (hold_q < HoldSat) begin
          hold_d = hold_q + 1'b1;
        end
      end
      StTurn: begin
        if (turn_q == '0) begin
          arbitrate = 1'b1;
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (arbitrate) begin
      gnt_d = '0;
      if (arb_valid) begin
        state_d        = StOwn;
        gnt_d[arb_idx] = 1'b1;
        owner_d        = arb_idx;
        hold_d         = '0;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= LastInit;
      hold_q     <= '0;
      turn_q     <= '0;
      gnt_q      <= '0;
      rdata_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      turn_q     <= turn_d;
      gnt_q      <= gnt_d;
      rdata_q    <= bus;
      conflict_q <= conflict_d;
    end
  end

`ifdef SHARED_BUS_KEEPER_EN
  logic [WIDTH-1:0] keep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keep_q <= '0;
    end else if (drive_en) begin
      keep_q <= drive_data;
    end
  end

  assign (weak0, weak1) bus = drive_en ? {WIDTH{1'bz}} : keep_q;
`endif

  assign gnt      = gnt_q;
  assign busy     = drive_en;
  assign rdata    = rdata_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter: default instance plus a TURNAROUND=0 instance.
module tb_shared_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, req0;
  logic [31:0] wdata, wdata0;
  logic [3:0]  gnt, gnt0;
  tri   [7:0]  bus, bus0;
  logic [7:0]  rdata, rdata0;
  logic        busy, busy0, conflict, conflict0;

  logic        pull_en;
  logic        ext_en;
  logic [7:0]  ext_val;

  int errors = 0;
  int checks = 0;

  // A released bus is pulled to 8'h5A, so any stray DUT drive shows up as a wrong value.
  assign bus  = (pull_en && gnt == 4'b0000) ? 8'h5A : 8'hzz;
  assign bus  = ext_en ? ext_val : 8'hzz;
  assign bus0 = (gnt0 == 4'b0000) ? 8'h5A : 8'hzz;

  shared_bus_arbiter u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .bus      (bus),
    .rdata    (rdata),
    .busy     (busy),
    .conflict (conflict)
  );

  shared_bus_arbiter #(
    .TURNAROUND (0)
  ) u_dut_t0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req0),
    .wdata    (wdata0),
    .gnt      (gnt0),
    .bus      (bus0),
    .rdata    (rdata0),
    .busy     (busy0),
    .conflict (conflict0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_gnt;
    logic [7:0] exp_bus;

    rst_n   = 1'b0;
    req     = 4'b0000;
    req0    = 4'b0000;
    wdata   = {8'h44, 8'h33, 8'h22, 8'h11};
    wdata0  = {8'h44, 8'h33, 8'h22, 8'h11};
    pull_en = 1'b1;
    ext_en  = 1'b0;
    ext_val = 8'h00;

    // Reset state
    #3;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_conflict", 32'(conflict), 32'h0);
    check("rst_bus_released", 32'(bus), 32'h5A);
    #9 rst_n = 1'b1;
    tick(1);

    // All four channels requesting: 4-cycle tenures, 1 released cycle between, 0 first
    req = 4'b1111;
    for (int i = 0; i < 23; i++) begin
      tick(1);
      if (i % 5 == 4) begin
        exp_gnt = 4'b0000;
        exp_bus = 8'h5A;
      end else begin
        exp_gnt = 4'b0001 << ((i / 5) % 4);
        exp_bus = 8'h11 + 8'(((i / 5) % 4) * 8'h11);
      end
      check($sformatf("rr_gnt[%0d]", i), 32'(gnt), 32'(exp_gnt));
      check($sformatf("rr_bus[%0d]", i), 32'(bus), 32'(exp_bus));
    end
    req = 4'b0000;
    tick(3);
    check("rr_idle_gnt", 32'(gnt), 32'h0);
    check("rr_idle_busy", 32'(busy), 32'h0);

    // Lone requester on channel 2, held past the hold limit
    wdata[23:16] = 8'hA5;
    req = 4'b0100;
    tick(1);
    check("solo_gnt", 32'(gnt), 32'b0100);
    check("solo_bus", 32'(bus), 32'hA5);
    check("solo_busy", 32'(busy), 32'h1);
    tick(1);
    check("solo_rdata", 32'(rdata), 32'hA5);
    tick(6);
    check("solo_hold_gnt", 32'(gnt), 32'b0100);
    req = 4'b0000;
    tick(1);
    check("solo_release_gnt", 32'(gnt), 32'h0);
    check("solo_release_bus", 32'(bus), 32'h5A);
    tick(2);

    // Bus contention: owner 1 drives 00, bench forces bit 0 high
    pull_en = 1'b0;
    wdata[15:8] = 8'h00;
    req = 4'b0010;
    tick(1);
    check("cfl_gnt", 32'(gnt), 32'b0010);
    check("cfl_before", 32'(conflict), 32'h0);
    ext_val = 8'h01;
    ext_en  = 1'b1;
    #1;
    check("cfl_bit0_not_driven", 32'(bus[0] !== 1'b0), 32'h1);
    check("cfl_upper_bits", 32'(bus[7:1]), 32'h0);
    tick(1);
    check("cfl_set", 32'(conflict), 32'h1);
    ext_en = 1'b0;
    req    = 4'b0000;
    tick(4);
    check("cfl_sticky", 32'(conflict), 32'h1);
    pull_en = 1'b1;

    // Asynchronous reset in the middle of an ownership
    req = 4'b1000;
    tick(1);
    check("arst_pre_gnt", 32'(gnt), 32'b1000);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_bus", 32'(bus), 32'h5A);
    check("arst_conflict", 32'(conflict), 32'h0);
    check("arst_rdata", 32'(rdata), 32'h0);
    #2 rst_n = 1'b1;
    req = 4'b1001;
    tick(1);
    check("arst_first_winner", 32'(gnt), 32'b0001);
    req = 4'b0000;
    tick(3);

    // Zero turnaround: handover from channel 0 to 3 at one edge
    req0 = 4'b1001;
    tick(1);
    check("t0_gnt_a", 32'(gnt0), 32'b0001);
    check("t0_bus_a", 32'(bus0), 32'h11);
    req0 = 4'b1000;
    tick(1);
    check("t0_gnt_b", 32'(gnt0), 32'b1000);
    check("t0_bus_b", 32'(bus0), 32'h44);
    tick(1);
    check("t0_gnt_c", 32'(gnt0), 32'b1000);
    req0 = 4'b0000;
    tick(2);
    check("t0_idle", 32'(gnt0), 32'h0);

`ifdef SHARED_BUS_KEEPER_EN
    // Keeper holds the last owned value through turnaround and idle
    pull_en = 1'b0;
    wdata[15:8] = 8'h3C;
    req = 4'b0010;
    tick(1);
    check("keep_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    tick(1);
    check("keep_turn_bus", 32'(bus), 32'h3C);
    tick(1);
    check("keep_idle_bus", 32'(bus), 32'h3C);
    tick(1);
    check("keep_rdata", 32'(rdata), 32'h3C);
    check("keep_conflict", 32'(conflict), 32'h0);
    pull_en = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
